// File: rtl/iccm_spi_boot_ctrl_if.sv
// Bus bundle between the boot controller, the SPI instruction pins and the ICCM control port.
interface iccm_spi_boot_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  spi_ss;
    logic                  spi_mosi;
    logic                  iccm_cntrl_reset;
    logic                  iccm_cntrl_we;
    logic [ADDR_WIDTH-1:0] iccm_cntrl_addr;
    logic [DATA_WIDTH-1:0] iccm_cntrl_data;

    modport master (
        input  spi_ss,
        input  spi_mosi,
        output iccm_cntrl_reset,
        output iccm_cntrl_we,
        output iccm_cntrl_addr,
        output iccm_cntrl_data
    );

    modport slave (
        output spi_ss,
        output spi_mosi,
        input  iccm_cntrl_reset,
        input  iccm_cntrl_we,
        input  iccm_cntrl_addr,
        input  iccm_cntrl_data
    );
endinterface

// File: rtl/iccm_spi_boot_ctrl.sv
// SPI boot loader: shifts MSB-first words into consecutive ICCM words, then hands ICCM to the xbar
// and releases the core reset. Define ICCM_BOOT_CHKSUM_EN for a running sum of written words.
module iccm_spi_boot_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int RST_DLY    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    iccm_spi_boot_ctrl_if.master  bus,
    output logic                  enable_rst_ni,
    output logic [ADDR_WIDTH:0]   words_loaded_o,
    output logic                  frame_err_o,
    output logic                  ovf_o,
    output logic [DATA_WIDTH-1:0] load_chksum_o
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int DLY_W = $clog2(RST_DLY + 1);
    localparam logic [CNT_W-1:0]    BITS_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_GAP     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RUN     = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
    logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
    logic [DLY_W-1:0]      dly_r, dly_s;
    logic                  we_r, we_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [ADDR_WIDTH:0]   loaded_r, loaded_s;
    logic                  ferr_r, ferr_s;
    logic                  ovf_r, ovf_s;
    logic                  own_r, own_s;
    logic                  en_rst_r, en_rst_s;
`ifdef ICCM_BOOT_CHKSUM_EN
    logic [DATA_WIDTH-1:0] chk_r, chk_s;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-value logic for the datapath registers
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_cnt_s = bit_cnt_r;
        dly_s     = dly_r;
        we_s      = 1'b0;
        addr_s    = addr_r;
        data_s    = data_r;
        loaded_s  = loaded_r;
        ferr_s    = ferr_r;
        ovf_s     = ovf_r;
        own_s     = own_r;
        en_rst_s  = en_rst_r;
`ifdef ICCM_BOOT_CHKSUM_EN
        chk_s     = chk_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // A falling frame select wins over a pending boot request; its first bit is taken now.
                if (!bus.spi_ss) begin
                    shreg_s   = {shreg_r[DATA_WIDTH-2:0], bus.spi_mosi};
                    bit_cnt_s = CNT_W'(1);
                    state_s   = ST_SHIFT;
                end else if (en_i) begin
                    own_s   = 1'b0;
                    dly_s   = DLY_W'(RST_DLY);
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bus.spi_ss) begin
                    shreg_s   = {shreg_r[DATA_WIDTH-2:0], bus.spi_mosi};
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_s == BITS_FULL) begin
                        state_s = ST_WRITE;
                        if (loaded_r < DEPTH_LIM) begin
                            we_s   = 1'b1;
                            data_s = shreg_s;
                        end else begin
                            ovf_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    ferr_s    = 1'b1;
                    bit_cnt_s = '0;
                    state_s   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Pointer advances on the edge that ends the strobe cycle; never past DEPTH.
                if (we_r) begin
                    addr_s   = addr_r + ADDR_WIDTH'(1);
                    loaded_s = loaded_r + (ADDR_WIDTH + 1)'(1);
`ifdef ICCM_BOOT_CHKSUM_EN
                    chk_s    = chk_r + data_r;
`endif
                end else begin
                    addr_s = addr_r;
                end
                state_s = ST_GAP;
            end
            ST_GAP: begin
                if (bus.spi_ss) begin
                    bit_cnt_s = '0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_RELEASE: begin
                if (dly_r <= DLY_W'(1)) begin
                    dly_s    = '0;
                    en_rst_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    dly_s = dly_r - DLY_W'(1);
                end
            end
            ST_RUN: begin
                own_s    = 1'b0;
                en_rst_s = 1'b1;
                state_s  = ST_RUN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_r   <= '0;
            bit_cnt_r <= '0;
            dly_r     <= '0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            loaded_r  <= '0;
            ferr_r    <= 1'b0;
            ovf_r     <= 1'b0;
            own_r     <= 1'b1;
            en_rst_r  <= 1'b0;
`ifdef ICCM_BOOT_CHKSUM_EN
            chk_r     <= '0;
`endif
        end else begin
            shreg_r   <= shreg_s;
            bit_cnt_r <= bit_cnt_s;
            dly_r     <= dly_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
            loaded_r  <= loaded_s;
            ferr_r    <= ferr_s;
            ovf_r     <= ovf_s;
            own_r     <= own_s;
            en_rst_r  <= en_rst_s;
`ifdef ICCM_BOOT_CHKSUM_EN
            chk_r     <= chk_s;
`endif
        end
    end

    assign bus.iccm_cntrl_reset = own_r;
    assign bus.iccm_cntrl_we    = we_r;
    assign bus.iccm_cntrl_addr  = addr_r;
    assign bus.iccm_cntrl_data  = data_r;
    assign enable_rst_ni        = en_rst_r;
    assign words_loaded_o       = loaded_r;
    assign frame_err_o          = ferr_r;
    assign ovf_o                = ovf_r;
`ifdef ICCM_BOOT_CHKSUM_EN
    assign load_chksum_o        = chk_r;
`else
    assign load_chksum_o        = '0;
`endif
endmodule

// File: tb/tb_iccm_spi_boot_ctrl.sv
// Scoreboard bench for iccm_spi_boot_ctrl: random words, expected ICCM writes queued by a word-level model.
module tb_iccm_spi_boot_ctrl;
    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int DEPTH   = 6;
    localparam int RST_DLY = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          enable_rst_ni;
    logic [AW:0]   words_loaded_o;
    logic          frame_err_o;
    logic          ovf_o;
    logic [DW-1:0] load_chksum_o;

    iccm_spi_boot_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    iccm_spi_boot_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RST_DLY(RST_DLY)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .bus            (bus),
        .enable_rst_ni  (enable_rst_ni),
        .words_loaded_o (words_loaded_o),
        .frame_err_o    (frame_err_o),
        .ovf_o          (ovf_o),
        .load_chksum_o  (load_chksum_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Word-level reference model of the loader
    int            exp_ptr;
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] exp_last;
    logic          exp_ferr;
    logic          exp_ovf;
    bit            loading;
    int            last_close;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_chk();
`ifdef ICCM_BOOT_CHKSUM_EN
        return exp_sum;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        exp_ptr  = 0;
        exp_sum  = '0;
        exp_last = '0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        loading  = 1'b1;
        sb.delete();
    endtask

    task automatic model_word(input logic [DW-1:0] w, input int c);
        if (exp_ptr < DEPTH) begin
            sb.push_back('{addr: AW'(exp_ptr), data: w, cyc: c + 1});
            exp_ptr++;
            exp_sum  = exp_sum + w;
            exp_last = w;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        en_i = 1'b0;
        bus.spi_ss = 1'b1;
        bus.spi_mosi = 1'b0;
        #1;
        chk("rst_iccm_reset", bus.iccm_cntrl_reset, 1'b1);
        chk("rst_we", bus.iccm_cntrl_we, 1'b0);
        chk("rst_addr", bus.iccm_cntrl_addr, '0);
        chk("rst_data", bus.iccm_cntrl_data, '0);
        chk("rst_enable_rst_ni", enable_rst_ni, 1'b0);
        chk("rst_words_loaded", words_loaded_o, '0);
        chk("rst_frame_err", frame_err_o, 1'b0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_chksum", load_chksum_o, '0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input int nbits, input int en_at, input int gap);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.spi_ss = 1'b0;
            bus.spi_mosi = w[DW-1-i];
            if (i == en_at) en_i = 1'b1;
            if (i == DW - 1 && loading) model_word(w, cyc);
        end
        if (nbits < DW && loading) exp_ferr = 1'b1;
        if (nbits == DW) begin
            @(negedge clk);
            bus.spi_mosi = 1'b0;
        end
        @(negedge clk);
        bus.spi_ss = 1'b1;
        bus.spi_mosi = 1'($urandom_range(0, 1));
        last_close = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_words_loaded"}, words_loaded_o, exp_ptr);
        chk({tag, "_addr"}, bus.iccm_cntrl_addr, exp_ptr);
        chk({tag, "_data"}, bus.iccm_cntrl_data, exp_last);
        chk({tag, "_frame_err"}, frame_err_o, exp_ferr);
        chk({tag, "_ovf"}, ovf_o, exp_ovf);
        chk({tag, "_chksum"}, load_chksum_o, exp_chk());
    endtask

    // Monitor: every write strobe must match the oldest expected write, including its cycle
    always @(negedge clk) begin
        if (bus.iccm_cntrl_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we actual addr=%0h data=%0h expected no write", bus.iccm_cntrl_addr, bus.iccm_cntrl_data);
            end else begin
                mon_e = sb.pop_front();
                chk("we_addr", bus.iccm_cntrl_addr, mon_e.addr);
                chk("we_data", bus.iccm_cntrl_data, mon_e.data);
                chk("we_latency", cyc, mon_e.cyc);
            end
        end
    end

    int fall_c;
    int rise_c;

    initial begin
        bus.spi_ss = 1'b1;
        bus.spi_mosi = 1'b0;
        model_reset();
        do_reset();

        // Two fixed words
        send_frame(32'h0000_0013, DW, -1, 1);
        send_frame(32'hDEAD_BEEF, DW, -1, 1);
        repeat (2) @(negedge clk);
        check_status("t1");
        chk("t1_words_two", words_loaded_o, 2);

        // Partial frame, then fill memory past DEPTH
        do_reset();
        send_frame($urandom(), 10, -1, 1);
        chk("t2_frame_err", frame_err_o, 1'b1);
        send_frame(32'h1234_5678, DW, -1, $urandom_range(0, 2));
        send_frame($urandom(), $urandom_range(1, DW - 1), -1, $urandom_range(0, 2));
        for (int k = 0; k < 4; k++) send_frame($urandom(), DW, -1, $urandom_range(0, 2));
        repeat (2) @(negedge clk);
        chk("t2_ovf_before_full", ovf_o, 1'b0);
        send_frame($urandom(), DW, -1, 1);
        repeat (2) @(negedge clk);
        chk("t2_ovf_at_depth", ovf_o, 1'b0);
        send_frame($urandom(), DW, -1, 1);
        send_frame($urandom(), DW, -1, 1);
        repeat (2) @(negedge clk);
        check_status("t4");

        // Boot request mid-word, then release timing
        do_reset();
        for (int k = 0; k < 2; k++) send_frame($urandom(), DW, -1, $urandom_range(0, 2));
        send_frame($urandom(), DW, 20, 0);
        loading = 1'b0;
        fall_c = -1;
        rise_c = -1;
        for (int k = 0; k < 40 && rise_c < 0; k++) begin
            @(negedge clk);
            if (fall_c < 0 && bus.iccm_cntrl_reset === 1'b0) fall_c = cyc;
            if (enable_rst_ni === 1'b1) rise_c = cyc;
        end
        chk("t3_handover_cycle", fall_c, last_close + 2);
        chk("t3_release_cycle", rise_c, last_close + 2 + RST_DLY);
        check_status("t3");

        // SPI traffic while running must be ignored
        for (int k = 0; k < 2; k++) send_frame($urandom(), DW, -1, 1);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        check_status("t6");
        chk("t6_enable_rst_ni", enable_rst_ni, 1'b1);
        chk("t6_iccm_reset", bus.iccm_cntrl_reset, 1'b0);

        // Reset during release, then a fresh load from address 0
        do_reset();
        send_frame($urandom(), DW, -1, 0);
        en_i = 1'b1;
        loading = 1'b0;
        fall_c = -1;
        for (int k = 0; k < 20 && fall_c < 0; k++) begin
            @(negedge clk);
            if (bus.iccm_cntrl_reset === 1'b0) fall_c = cyc;
        end
        chk("t5_entered_release", fall_c >= 0, 1'b1);
        chk("t5_still_held", enable_rst_ni, 1'b0);
        do_reset();
        for (int k = 0; k < 2; k++) send_frame($urandom(), DW, -1, $urandom_range(0, 2));
        repeat (2) @(negedge clk);
        check_status("t5");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iccm_spi_boot_ctrl.md
Name: iccm_spi_boot_ctrl

Overview:
Boot-load sequencer between the SPI instruction pins and the ICCM control port of opentitan_soc_core.
- Assembles MSB-first serial words framed by spi_ss.
- Writes each word into ICCM at consecutive word addresses.
- Holds the core in reset while loading; on en_i, hands the ICCM to the xbar and releases enable_rst_ni after a programmable delay.

Parameters:
DATA_WIDTH, 32, serial word width and iccm_cntrl_data width
ADDR_WIDTH, 12, iccm_cntrl_addr width (word address)
DEPTH, 4096, number of ICCM words; writes at addr >= DEPTH are dropped
RST_DLY, 4, cycles between ICCM handover and enable_rst_ni release (>=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  boot request, level, sampled on posedge
spi_ss  in  1  frame select, active-low, changes on negedge clk_i
spi_mosi  in  1  serial data, MSB first, changes on negedge clk_i
iccm_cntrl_reset  out  1  1 = ICCM owned by loader, 0 = owned by xbar
iccm_cntrl_we  out  1  one-cycle write strobe
iccm_cntrl_addr  out  ADDR_WIDTH  word write address
iccm_cntrl_data  out  DATA_WIDTH  write data
enable_rst_ni  out  1  core/memory reset, active-low
words_loaded_o  out  ADDR_WIDTH+1  count of words accepted
frame_err_o  out  1  sticky: spi_ss rose mid-word
ovf_o  out  1  sticky: word received with addr >= DEPTH
load_chksum_o  out  DATA_WIDTH  see Optional Feature

Behaviour:
- Reset (async, rst_ni=0) values:
  - iccm_cntrl_reset=1, iccm_cntrl_we=0, addr=0, data=0, enable_rst_ni=0.
  - words_loaded_o=0, frame_err_o=0, ovf_o=0, load_chksum_o=0.
  - Shift register and bit counter cleared; state=IDLE.
- All logic is on posedge clk_i. spi_ss and spi_mosi are sampled directly, with no synchronizer; they share clk_i.
- IDLE:
  - spi_ss=0 -> SHIFT. The first bit is sampled in this same cycle.
  - en_i=1 with spi_ss=1 -> RELEASE.
  - spi_ss=0 takes priority over en_i.
- SHIFT:
  - Each cycle with spi_ss=0: shreg <= {shreg[DATA_WIDTH-2:0], spi_mosi}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH -> WRITE.
  - spi_ss=1 with 0 < bit_cnt < DATA_WIDTH: partial word discarded, frame_err_o set, bit_cnt cleared -> IDLE.
- WRITE, exactly 1 cycle:
  - If addr < DEPTH: iccm_cntrl_we=1, iccm_cntrl_data=shreg, iccm_cntrl_addr=current addr. addr and words_loaded_o increment on the following edge.
  - Else: we stays 0, ovf_o set, addr holds.
  - Next state is GAP.
  - Latency: strobe is high in the cycle after the 32nd bit is sampled.
- GAP:
  - Bits while spi_ss stays low are ignored (the driver emits a trailing 0 bit).
  - spi_ss=1 -> IDLE, bit_cnt cleared.
- en_i asserted in SHIFT/WRITE/GAP is not acted on until the frame closes and the controller returns to IDLE. en_i level is rechecked there.
- RELEASE:
  - iccm_cntrl_reset=0 on entry; counter loads RST_DLY.
  - Counter reaches 0 -> enable_rst_ni=1 -> RUN.
  - Any spi_ss activity in RELEASE or RUN is ignored; no writes occur.
- RUN: terminal until rst_ni.
  - enable_rst_ni=1, iccm_cntrl_reset=0.
  - en_i deassertion has no effect.
- iccm_cntrl_addr holds its last value outside WRITE. iccm_cntrl_data holds the last written word.
- Address arithmetic is unsigned and saturates at DEPTH (no wrap).
  - words_loaded_o is ADDR_WIDTH+1 wide, so DEPTH=4096 is representable.
- Reset mid-word or mid-RELEASE: immediate return to reset values. The partial word is lost; the ICCM keeps previously written words.

Optional Feature:
Macro: ICCM_BOOT_CHKSUM_EN.
- Defined: load_chksum_o accumulates the modulo-2^DATA_WIDTH sum of every word actually written (we=1). It updates on the edge ending WRITE and freezes once RELEASE is entered.
- Not defined: load_chksum_o tied to 0 and no adder is synthesized.

Test Plan:
1. Reset, then shift 0x00000013 and 0xDEADBEEF (33 bits low each, ss high 2 cycles) -> we pulses at addr 0 with data 0x00000013 and at addr 1 with data 0xDEADBEEF, each 1 cycle after the 32nd bit. words_loaded_o=2; with CHKSUM_EN, load_chksum_o=0xDEADBF02.
2. ss high after 10 bits of a word -> frame_err_o=1, no we pulse. The next full word 0x12345678 is written at addr 0.
3. en_i=1 while bit 20 is shifting -> that word completes and is written. Then iccm_cntrl_reset falls in IDLE+1 and enable_rst_ni rises exactly RST_DLY=4 cycles later.
4. DEPTH=2, load 3 words -> only addr 0 and 1 are written, ovf_o=1, words_loaded_o=2, addr stays 2.
5. rst_ni pulsed low during RELEASE -> iccm_cntrl_reset=1 and enable_rst_ni=0 asynchronously. A new load restarts at addr 0.
6. SPI traffic in RUN -> no we pulses; all outputs are stable.
